// File: rtl/mem_bus_master_if.sv
// mem_bus_master_if -- CPU-side and MemControl-side signals of mem_bus_master.
//
// Groups the load/store handshake and the unidirectional bus signals. The
// shared tri-state data bus is not carried here; it stays a module inout so
// the resolved net lives at the level where every driver is visible.
//
// Signals:
//   cpu_req    request strobe, accepted only while busy=0
//   cpu_we     1 = store, 0 = load
//   cpu_addr   byte address, must be word aligned
//   cpu_wdata  store data
//   busy       transaction in progress
//   cpu_ack    one-cycle completion pulse
//   cpu_err    one-cycle pulse with cpu_ack on a misaligned request
//   cpu_rdata  load data, valid with cpu_ack after a load, then held
//   addr       bus address
//   rw         1 = read, 0 = write
//   valid      bus transaction active
//
// Modports:
//   master  view taken by mem_bus_master
//   slave   view taken by the requester and the memory side

interface mem_bus_master_if #(
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned CPUAWIDTH = 32
);
    logic                 cpu_req;
    logic                 cpu_we;
    logic [CPUAWIDTH-1:0] cpu_addr;
    logic [DWIDTH-1:0]    cpu_wdata;
    logic                 busy;
    logic                 cpu_ack;
    logic                 cpu_err;
    logic [DWIDTH-1:0]    cpu_rdata;
    logic [CPUAWIDTH-1:0] addr;
    logic                 rw;
    logic                 valid;

    modport master (
        input  cpu_req,
        input  cpu_we,
        input  cpu_addr,
        input  cpu_wdata,
        output busy,
        output cpu_ack,
        output cpu_err,
        output cpu_rdata,
        output addr,
        output rw,
        output valid
    );

    modport slave (
        output cpu_req,
        output cpu_we,
        output cpu_addr,
        output cpu_wdata,
        input  busy,
        input  cpu_ack,
        input  cpu_err,
        input  cpu_rdata,
        input  addr,
        input  rw,
        input  valid
    );
endinterface

// File: rtl/mem_bus_master.sv
// mem_bus_master -- CPU-side initiator for the MemControl memory bus.
//
// Accepts one load/store at a time from the load/store stage, checks word
// alignment, holds valid for MEM_LAT cycles while presenting the address
// (and write data for stores), captures read data on the last access edge,
// then spends one turnaround cycle with the bus released while pulsing
// cpu_ack (and cpu_err for a rejected misaligned request).
//
// Parameters:
//   DWIDTH     data bus width
//   CPUAWIDTH  address width (>= 2)
//   MEM_LAT    cycles valid is held per access, 1..15
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-low
//   bus    mem_bus_master_if.master: cpu_req/cpu_we/cpu_addr/cpu_wdata in,
//          busy/cpu_ack/cpu_err/cpu_rdata/addr/rw/valid out
//   data   shared tri-state data bus; driven only for a store in ACCESS

module mem_bus_master #(
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned CPUAWIDTH = 32,
    parameter int unsigned MEM_LAT   = 2
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_master_if.master  bus,
    inout  wire  [DWIDTH-1:0] data
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        TURN
    } state_t;

    // Counter starts at MEM_LAT-1 so that reaching zero marks the last
    // ACCESS cycle; ACCESS therefore lasts exactly MEM_LAT cycles.
    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

    state_t state_q;
    state_t state_d;

    logic [CPUAWIDTH-1:0] addr_q;
    logic                 we_q;
    logic [DWIDTH-1:0]    wdata_q;
    logic [DWIDTH-1:0]    rdata_q;
    logic                 err_q;
    logic [3:0]           cnt_q;

    logic misaligned;
    logic last_beat;
    logic accept;
    logic capture;
    logic drive_en;
    logic busy_c;
    logic valid_c;
    logic rw_c;
    logic ack_c;
    logic err_c;

    assign misaligned = |bus.cpu_addr[1:0];
    assign last_beat  = (cnt_q == '0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs; the bus is parked as an idle read with data
    // released unless a store is actively in ACCESS.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        capture  = 1'b0;
        drive_en = 1'b0;
        busy_c   = 1'b0;
        valid_c  = 1'b0;
        rw_c     = 1'b1;
        ack_c    = 1'b0;
        err_c    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.cpu_req) begin
                    accept = 1'b1;
                    // A misaligned request skips the bus entirely and only
                    // reports the error during the turnaround cycle.
                    state_d = misaligned ? TURN : ACCESS;
                end
            end

            ACCESS: begin
                busy_c   = 1'b1;
                valid_c  = 1'b1;
                rw_c     = ~we_q;
                drive_en = we_q;
                if (last_beat) begin
                    capture = ~we_q;
                    state_d = TURN;
                end
            end

            TURN: begin
                busy_c  = 1'b1;
                ack_c   = 1'b1;
                err_c   = err_q;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, access counter and read-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                err_q <= misaligned;
                // Address/data are only taken for a real bus access so a
                // rejected request leaves the bus address untouched.
                if (!misaligned) begin
                    addr_q  <= bus.cpu_addr;
                    we_q    <= bus.cpu_we;
                    wdata_q <= bus.cpu_wdata;
                    cnt_q   <= CNT_LOAD;
                end
            end else if (state_q == ACCESS && !last_beat) begin
                cnt_q <= cnt_q - 4'd1;
            end

            if (capture) begin
                rdata_q <= data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output wiring
    // ------------------------------------------------------------------
    assign bus.busy      = busy_c;
    assign bus.valid     = valid_c;
    assign bus.rw        = rw_c;
    assign bus.cpu_ack   = ack_c;
    assign bus.cpu_err   = err_c;
    assign bus.addr      = addr_q;
    assign bus.cpu_rdata = rdata_q;

    assign data = drive_en ? wdata_q : 'z;

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master -- self-checking bench for mem_bus_master.
//
// A simple MemControl stand-in (word array) answers reads on the shared bus
// and absorbs writes. Expected behaviour comes from a reference model of the
// access sequence: cycle k after the accepting edge, golden memory contents,
// last accepted address and last load result.

module tb_mem_bus_master;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 32;
    localparam int unsigned LAT = 2;
    localparam int unsigned NT  = LAT + 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    wire [DW-1:0] data;

    always #5 clk = ~clk;

    mem_bus_master_if #(.DWIDTH(DW), .CPUAWIDTH(AW)) bus ();

    mem_bus_master #(
        .DWIDTH   (DW),
        .CPUAWIDTH(AW),
        .MEM_LAT  (LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .data (data)
    );

    // MemControl stand-in
    logic [DW-1:0] mem_arr [0:63];
    assign data = (bus.valid === 1'b1 && bus.rw === 1'b1) ? mem_arr[bus.addr[7:2]] : 'z;
    always @(posedge clk) begin
        if (bus.valid === 1'b1 && bus.rw === 1'b0) mem_arr[bus.addr[7:2]] <= data;
    end

    // Reference model state
    logic [DW-1:0] golden [0:63];
    logic [DW-1:0] exp_rdata;
    logic [AW-1:0] exp_addr;

    int tests_run = 0;
    int failed    = 0;

    // Trace of one access, index k = cycles after the accepting edge
    logic [4:0]    tr_st    [1:NT];
    logic [AW-1:0] tr_addr  [1:NT];
    logic [DW-1:0] tr_data  [1:NT];
    logic [DW-1:0] tr_rdata [1:NT];

    // {valid, rw, cpu_ack, cpu_err, busy} k cycles after acceptance
    function automatic logic [4:0] exp_status(input logic we, input logic mis, input int unsigned k);
        if (mis) return (k == 1) ? 5'b01111 : 5'b01000;
        if (k <= LAT) return {1'b1, ~we, 1'b0, 1'b0, 1'b1};
        if (k == LAT + 1) return 5'b01101;
        return 5'b01000;
    endfunction

    // Bus released: 'z in a 4-state simulator, undriven zero otherwise
    function automatic bit released(input logic [DW-1:0] v);
        return $isunknown(v) || (v == '0);
    endfunction

    // Requester: waits for busy=0 (bounded), presents one request, records
    // NT cycles. With hold=1 cpu_req stays high and the other inputs are
    // scrambled while busy.
    task automatic run_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input bit hold, output int unsigned waited);
        waited = 0;
        while (bus.busy !== 1'b0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = wd;
        for (int unsigned k = 1; k <= NT; k++) begin
            @(negedge clk);
            tr_st[k]    = {bus.valid, bus.rw, bus.cpu_ack, bus.cpu_err, bus.busy};
            tr_addr[k]  = bus.addr;
            tr_data[k]  = data;
            tr_rdata[k] = bus.cpu_rdata;
            if (k == 1) begin
                if (hold) begin
                    bus.cpu_we    = ~we;
                    bus.cpu_addr  = $urandom;
                    bus.cpu_wdata = $urandom;
                end else begin
                    bus.cpu_req = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [4:0] st;
        for (int unsigned k = 1; k <= 2; k++) begin
            @(negedge clk);
            st = {bus.valid, bus.rw, bus.cpu_ack, bus.cpu_err, bus.busy};
            tests_run++;
            if (st !== 5'b01000) begin
                failed++; $display("FAIL reset_status c%0d: got %b want 01000", k, st);
            end
            tests_run++;
            if (bus.addr !== '0) begin
                failed++; $display("FAIL reset_addr c%0d: got %h want 0", k, bus.addr);
            end
            tests_run++;
            if (bus.cpu_rdata !== '0) begin
                failed++; $display("FAIL reset_rdata c%0d: got %h want 0", k, bus.cpu_rdata);
            end
            tests_run++;
            if (!released(data)) begin
                failed++; $display("FAIL reset_data c%0d: got %h want released", k, data);
            end
        end
        reset       = 1'b1;
        bus.cpu_req = 1'b0;
        exp_rdata   = '0;
        exp_addr    = '0;
    endtask

    task automatic test_store();
        int unsigned w;
        run_access(1'b1, 32'd4, 32'hDEADBEEF, 1'b0, w);
        exp_addr = 32'd4;
        for (int unsigned k = 1; k <= NT; k++) begin
            tests_run++;
            if (tr_st[k] !== exp_status(1'b1, 1'b0, k)) begin
                failed++; $display("FAIL store_status c%0d: got %b want %b", k, tr_st[k], exp_status(1'b1, 1'b0, k));
            end
            tests_run++;
            if (tr_addr[k] !== 32'd4) begin
                failed++; $display("FAIL store_addr c%0d: got %h want 4", k, tr_addr[k]);
            end
            tests_run++;
            if (k <= LAT ? (tr_data[k] !== 32'hDEADBEEF) : !released(tr_data[k])) begin
                failed++; $display("FAIL store_data c%0d: got %h want %s", k, tr_data[k], k <= LAT ? "deadbeef" : "released");
            end
            tests_run++;
            if (tr_rdata[k] !== exp_rdata) begin
                failed++; $display("FAIL store_rdata c%0d: got %h want %h", k, tr_rdata[k], exp_rdata);
            end
        end
        golden[1] = 32'hDEADBEEF;
    endtask

    task automatic test_load_back();
        int unsigned w;
        logic [DW-1:0] wd;
        for (int unsigned i = 0; i < 3; i++) begin
            wd = $urandom | 32'h1;
            run_access(1'b1, 32'(i * 4), wd, 1'b0, w);
            golden[i] = wd;
        end
        for (int unsigned i = 0; i < 3; i++) begin
            run_access(1'b0, 32'(i * 4), '0, 1'b0, w);
            exp_addr = 32'(i * 4);
            for (int unsigned k = 1; k <= LAT; k++) begin
                tests_run++;
                if (tr_st[k] !== 5'b11001 || tr_data[k] !== golden[i]) begin
                    failed++; $display("FAIL loadback_access a%0d c%0d: got st %b data %h want st 11001 data %h",
                                       i * 4, k, tr_st[k], tr_data[k], golden[i]);
                end
            end
            tests_run++;
            if (tr_st[LAT+1] !== 5'b01101 || tr_rdata[LAT+1] !== golden[i]) begin
                failed++; $display("FAIL loadback_ack a%0d: got st %b rdata %h want st 01101 rdata %h",
                                   i * 4, tr_st[LAT+1], tr_rdata[LAT+1], golden[i]);
            end
            tests_run++;
            if (tr_rdata[NT] !== golden[i]) begin
                failed++; $display("FAIL loadback_hold a%0d: got %h want %h", i * 4, tr_rdata[NT], golden[i]);
            end
            exp_rdata = golden[i];
        end
    endtask

    task automatic test_misaligned();
        int unsigned w;
        logic [AW-1:0] a;
        logic we;
        for (int unsigned n = 0; n < 2; n++) begin
            we = (n == 1);
            a  = (n == 0) ? 32'd6 : 32'd9;
            run_access(we, a, $urandom | 32'h1, 1'b0, w);
            for (int unsigned k = 1; k <= NT; k++) begin
                tests_run++;
                if (tr_st[k] !== exp_status(we, 1'b1, k)) begin
                    failed++; $display("FAIL misaligned_status a%0d c%0d: got %b want %b", a, k, tr_st[k], exp_status(we, 1'b1, k));
                end
                tests_run++;
                if (tr_addr[k] !== exp_addr || tr_rdata[k] !== exp_rdata || !released(tr_data[k])) begin
                    failed++; $display("FAIL misaligned_regs a%0d c%0d: got addr %h rdata %h data %h want addr %h rdata %h data released",
                                       a, k, tr_addr[k], tr_rdata[k], tr_data[k], exp_addr, exp_rdata);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int unsigned w;
        int unsigned idx = 0;
        logic we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd = '0;
        logic [4:0] es;
        for (int unsigned i = 0; i < 8; i++) begin
            we = (i % 2 == 0);
            if (we) begin
                idx = $urandom_range(0, 15);
                wd  = $urandom | 32'h1;
            end
            a = 32'(idx << 2);
            run_access(we, a, wd, 1'b1, w);
            exp_addr = a;
            tests_run++;
            if (w != 0) begin
                failed++; $display("FAIL b2b_accept op%0d: got %0d extra wait cycles want 0", i, w);
            end
            for (int unsigned k = 1; k <= NT; k++) begin
                es = exp_status(we, 1'b0, k);
                tests_run++;
                if (tr_st[k] !== es || tr_addr[k] !== a) begin
                    failed++; $display("FAIL b2b_status op%0d c%0d: got st %b addr %h want st %b addr %h", i, k, tr_st[k], tr_addr[k], es, a);
                end
                tests_run++;
                if (k <= LAT ? (tr_data[k] !== (we ? wd : golden[idx])) : !released(tr_data[k])) begin
                    failed++; $display("FAIL b2b_data op%0d c%0d: got %h want %h", i, k, tr_data[k], we ? wd : golden[idx]);
                end
            end
            if (we) begin
                golden[idx] = wd;
            end else begin
                tests_run++;
                if (tr_rdata[LAT+1] !== golden[idx]) begin
                    failed++; $display("FAIL b2b_rdata op%0d: got %h want %h", i, tr_rdata[LAT+1], golden[idx]);
                end
                exp_rdata = golden[idx];
            end
        end
        bus.cpu_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        int unsigned w;
        logic [4:0] st;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'd8;
        @(negedge clk);
        tests_run++;
        if (bus.valid !== 1'b1) begin
            failed++; $display("FAIL resetmid_start: got valid %b want 1", bus.valid);
        end
        reset       = 1'b0;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        st = {bus.valid, bus.rw, bus.cpu_ack, bus.cpu_err, bus.busy};
        tests_run++;
        if (st !== 5'b01000 || !released(data)) begin
            failed++; $display("FAIL resetmid_abort: got st %b data %h want st 01000 data released", st, data);
        end
        reset = 1'b1;
        exp_rdata = '0;
        exp_addr  = '0;
        for (int unsigned k = 1; k <= NT; k++) begin
            @(negedge clk);
            tests_run++;
            if (bus.cpu_ack !== 1'b0 || bus.valid !== 1'b0) begin
                failed++; $display("FAIL resetmid_noack c%0d: got ack %b valid %b want 0 0", k, bus.cpu_ack, bus.valid);
            end
        end
        tests_run++;
        if (bus.cpu_rdata !== exp_rdata || bus.addr !== exp_addr) begin
            failed++; $display("FAIL resetmid_regs: got rdata %h addr %h want 0 0", bus.cpu_rdata, bus.addr);
        end
        run_access(1'b0, 32'd8, '0, 1'b0, w);
        exp_addr = 32'd8;
        tests_run++;
        if (tr_st[LAT+1] !== 5'b01101 || tr_rdata[LAT+1] !== golden[2]) begin
            failed++; $display("FAIL resetmid_reload: got st %b rdata %h want st 01101 rdata %h", tr_st[LAT+1], tr_rdata[LAT+1], golden[2]);
        end
        exp_rdata = golden[2];
    endtask

    task automatic test_random();
        int unsigned w;
        int unsigned idx;
        logic we, mis, acc;
        logic [AW-1:0] a;
        logic [DW-1:0] wd, new_rdata, ed;
        for (int unsigned n = 0; n < 46; n++) begin
            // First pass fills every word, then mixed traffic
            if (n < 16) begin
                idx = n; we = 1'b1; mis = 1'b0;
            end else begin
                idx = $urandom_range(0, 15);
                we  = 1'($urandom_range(0, 1));
                mis = ($urandom_range(0, 4) == 0);
            end
            wd = $urandom | 32'h1;
            a  = 32'(idx << 2);
            if (mis) a = a | 32'($urandom_range(1, 3));
            run_access(we, a, wd, 1'b0, w);
            if (!mis) exp_addr = a;
            new_rdata = (!mis && !we) ? golden[idx] : exp_rdata;
            for (int unsigned k = 1; k <= NT; k++) begin
                acc = !mis && (k <= LAT);
                tests_run++;
                if (tr_st[k] !== exp_status(we, mis, k) || tr_addr[k] !== exp_addr) begin
                    failed++; $display("FAIL rnd_status op%0d c%0d: got st %b addr %h want st %b addr %h",
                                       n, k, tr_st[k], tr_addr[k], exp_status(we, mis, k), exp_addr);
                end
                ed = we ? wd : golden[idx];
                tests_run++;
                if (acc ? (tr_data[k] !== ed) : !released(tr_data[k])) begin
                    failed++; $display("FAIL rnd_data op%0d c%0d: got %h want %s%h", n, k, tr_data[k], acc ? "" : "released not ", ed);
                end
                tests_run++;
                if (tr_rdata[k] !== ((k > LAT) ? new_rdata : exp_rdata)) begin
                    failed++; $display("FAIL rnd_rdata op%0d c%0d: got %h want %h", n, k, tr_rdata[k], (k > LAT) ? new_rdata : exp_rdata);
                end
            end
            if (!mis && we) golden[idx] = wd;
            exp_rdata = new_rdata;
        end
    endtask

    initial begin
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 32'd4;
        bus.cpu_wdata = 32'h1234_5679;
        reset         = 1'b0;
        test_reset();
        test_store();
        test_load_back();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000 time units want completion");
        $fatal(1);
    end

endmodule
